// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave exposing a user-fabric word snapshot with new-data/overrun flags and update counter.
// Optional capture timestamp at offset 0x8 when OPB_REG_TIMESTAMP_EN is defined.
module opb_register_simulink2ppc_snap #(
  parameter logic [31:0] C_BASEADDR   = 32'h01000000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010000FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [31:0]               user_data_in,
  input  logic                      user_data_valid
);

  typedef enum logic {StIdle, StAck} state_e;

  state_e      state_q, state_d;
  logic [31:0] snapshot_q;
  logic        new_flag_q, new_flag_d;
  logic        overrun_q, overrun_d;
  logic [15:0] upd_cnt_q;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_clr_q, rd_clr_d;
  logic        ovr_clr_q, ovr_clr_d;

  logic [31:0] addr, addr_off, reg_rd, tstamp_rd;
  logic [1:0]  word;
  logic        hit;
  logic        unused_sigs;

  assign addr     = OPB_ABus;
  assign addr_off = addr - C_BASEADDR;
  assign word     = addr_off[3:2];
  assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  assign unused_sigs = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29], OPB_DBus[31],
                         addr_off[31:4], addr_off[1:0]};

`ifdef OPB_REG_TIMESTAMP_EN
  logic [31:0] cyc_q, tstamp_q;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      cyc_q    <= '0;
      tstamp_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (user_data_valid) tstamp_q <= cyc_q;
    end
  end

  assign tstamp_rd = tstamp_q;
`else
  assign tstamp_rd = '0;
`endif

  always_comb begin
    reg_rd = '0;
    unique case (word)
      2'd0: reg_rd = snapshot_q;
      2'd1: reg_rd = {upd_cnt_q, 14'd0, overrun_q, new_flag_q};
      2'd2: reg_rd = tstamp_rd;
      2'd3: reg_rd = '0;
    endcase
  end

  // Read data and side-effect requests are latched when the select is sampled in idle.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    rd_clr_d  = 1'b0;
    ovr_clr_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (hit) begin
          state_d   = StAck;
          rdata_d   = OPB_RNW ? reg_rd : '0;
          rd_clr_d  = OPB_RNW && (word == 2'd0);
          ovr_clr_d = !OPB_RNW && (word == 2'd1) && OPB_BE[3] && OPB_DBus[30];
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A capture strobe always wins over a concurrent clear.
  always_comb begin
    new_flag_d = new_flag_q;
    overrun_d  = overrun_q;
    if (user_data_valid) begin
      new_flag_d = 1'b1;
    end else if (rd_clr_q) begin
      new_flag_d = 1'b0;
    end
    if (user_data_valid && new_flag_q && !rd_clr_q) begin
      overrun_d = 1'b1;
    end else if (ovr_clr_q) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      snapshot_q <= '0;
      new_flag_q <= 1'b0;
      overrun_q  <= 1'b0;
      upd_cnt_q  <= '0;
      rdata_q    <= '0;
      rd_clr_q   <= 1'b0;
      ovr_clr_q  <= 1'b0;
    end else begin
      new_flag_q <= new_flag_d;
      overrun_q  <= overrun_d;
      rdata_q    <= rdata_d;
      rd_clr_q   <= rd_clr_d;
      ovr_clr_q  <= ovr_clr_d;
      if (user_data_valid) begin
        snapshot_q <= user_data_in;
        upd_cnt_q  <= upd_cnt_q + 16'd1;
      end
    end
  end

  assign Sl_xferAck = (state_q == StAck);
  assign Sl_DBus    = Sl_xferAck ? rdata_q : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule
